// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary converter.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    // Accumulator width that holds every DIGITS-digit decimal value without loss.
    function automatic int bcd_acc_w(input int digits);
        int p;
        p = 1;
        for (int i = 0; i < digits; i++) begin
            p = p * 10;
        end
        return $clog2(p);
    endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Valid/ready input and output channels of the BCD-to-binary converter.
interface bcd2bin_seq_if #(
    parameter int N      = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [N-1:0]          data_out;
    logic                  ovf;
    logic                  err;

    modport master (
        output in_valid, bcd_in, out_ready,
        input  in_ready, out_valid, data_out, ovf, err
    );

    modport slave (
        input  in_valid, bcd_in, out_ready,
        output in_ready, out_valid, data_out, ovf, err
    );
endinterface

// File: rtl/bcd_digit_mac.sv
// One decimal step of the conversion: acc*10 + digit, built from two shifts and adds.
module bcd_digit_mac #(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [3:0]       digit_i,
    output logic [ACC_W-1:0] acc_o
);
    assign acc_o = (acc_i << 3) + (acc_i << 1) + ACC_W'(digit_i);
endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first.
// Define BCD2BIN_SAT_EN to saturate data_out on overflow instead of wrapping.
module bcd2bin_seq
    import bcd_pkg::*;
#(
    parameter int N      = 8,
    parameter int DIGITS = 3
) (
    input logic          clk,
    input logic          rst_n,
    bcd2bin_seq_if.slave bus
);
    localparam int ACC_W = bcd_acc_w(DIGITS);
    localparam int W     = 4 * DIGITS;
    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGITS - 1);

    state_t             state_q, state_d;
    logic [W-1:0]       shreg_q, shreg_d;
    logic [ACC_W-1:0]   acc_q, acc_d, acc_mac;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [N-1:0]       data_q, data_d, data_fmt, acc_low;
    logic               ovf_q, ovf_d, ovf_calc;
    logic               err_q, err_d, nib_err;

    bcd_digit_mac #(.ACC_W(ACC_W)) u_mac (
        .acc_i   (acc_q),
        .digit_i (shreg_q[W-1 -: 4]),
        .acc_o   (acc_mac)
    );

    generate
        if (ACC_W > N) begin : g_wide
            assign ovf_calc = |acc_mac[ACC_W-1:N];
            assign acc_low  = acc_mac[N-1:0];
        end else begin : g_narrow
            assign ovf_calc = 1'b0;
            assign acc_low  = N'(acc_mac);
        end
    endgenerate

    // An invalid digit forces a zero result whatever the overflow policy.
`ifdef BCD2BIN_SAT_EN
    assign data_fmt = err_q ? '0 : (ovf_calc ? {N{1'b1}} : acc_low);
`else
    assign data_fmt = err_q ? '0 : acc_low;
`endif

    always_comb begin
        nib_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bus.bcd_in[4*i +: 4] > BCD_DIGIT_MAX) nib_err = 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        data_d      = data_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    shreg_d = bus.bcd_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = nib_err;
                    state_d = CONV;
                end
            end
            CONV: begin
                acc_d   = acc_mac;
                shreg_d = shreg_q << 4;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    data_d      = data_fmt;
                    ovf_d       = ovf_calc;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the datapath registers are reset too, so an abort mid-conversion leaves no stale result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            data_q      <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq: directed vectors, a decimal reference model and a per-cycle compare process.
module tb_bcd2bin_seq;

`ifdef BCD2BIN_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [7:0] EXP_256 = SAT ? 8'hFF : 8'h00;
    localparam logic [7:0] EXP_999 = SAT ? 8'hFF : 8'hE7;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        logic       err;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd2bin_seq_if #(.N(8), .DIGITS(3)) bus ();

    bcd2bin_seq #(.N(8), .DIGITS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal value of the word; the 10-bit accumulator wraps only for invalid nibbles.
    function automatic exp_t model(input logic [11:0] w);
        exp_t r;
        int   v;
        int   d;
        bit   e;
        v = 0;
        e = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            d = int'(w[4*k +: 4]);
            if (d > 9) e = 1'b1;
            v = v * 10 + d;
        end
        v     = v % 1024;
        r.err = e;
        r.ovf = (v > 255);
        if (e)          r.data = 8'h00;
        else if (r.ovf) r.data = SAT ? 8'hFF : 8'(v % 256);
        else            r.data = 8'(v);
        return r;
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_n && bus.out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                check("model_data", 32'(bus.data_out), 32'(sb[0].data));
                check("model_ovf",  32'(bus.ovf),      32'(sb[0].ovf));
                check("model_err",  32'(bus.err),      32'(sb[0].err));
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
    end

    task automatic convert(input logic [11:0] w, input logic [7:0] ed, input logic eo,
                           input logic ee, input int hold);
        int lat;
        @(negedge clk);
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.bcd_in    = w;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        sb.push_back(model(w));
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            check("in_ready_conv", 32'(bus.in_ready), 32'd0);
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        check("data_out", 32'(bus.data_out), 32'(ed));
        check("ovf", 32'(bus.ovf), 32'(eo));
        check("err", 32'(bus.err), 32'(ee));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(bus.out_valid), 32'd1);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
            check("hold_data", 32'(bus.data_out), 32'(ed));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("released_valid", 32'(bus.out_valid), 32'd0);
        check("released_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [11:0] w;
        bus.in_valid  = 1'b0;
        bus.bcd_in    = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(bus.in_ready),  32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data",      32'(bus.data_out),  32'd0);
        check("rst_ovf",       32'(bus.ovf),       32'd0);
        check("rst_err",       32'(bus.err),       32'd0);
        rst_n = 1'b1;

        convert(12'h255, 8'hFF,   1'b0, 1'b0, 0);
        convert(12'h000, 8'h00,   1'b0, 1'b0, 0);
        convert(12'h256, EXP_256, 1'b1, 1'b0, 0);
        convert(12'h999, EXP_999, 1'b1, 1'b0, 0);
        convert(12'h1A3, 8'h00,   1'b0, 1'b1, 0);
        convert(12'h042, 8'h2A,   1'b0, 1'b0, 0);
        convert(12'h128, 8'h80,   1'b0, 1'b0, 5);

        // Abort a conversion of 200 one edge into CONV.
        @(negedge clk);
        bus.bcd_in    = 12'h200;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        sb.push_back(model(12'h200));
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_data",      32'(bus.data_out),  32'd0);
        check("abort_ovf",       32'(bus.ovf),       32'd0);
        check("abort_err",       32'(bus.err),       32'd0);
        check("abort_in_ready",  32'(bus.in_ready),  32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        convert(12'h017, 8'h11, 1'b0, 1'b0, 0);

        for (int i = 0; i < 256; i++) begin
            w = {4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)};
            convert(w, 8'(i), 1'b0, 1'b0, 0);
        end

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bcd2bin_seq.md
Name: bcd2bin_seq

Overview:
- Sequential BCD-to-binary converter, the inverse of the team's combinational bin2bcd block.
- Takes a packed DIGITS-digit BCD word through a valid/ready handshake.
- Accumulates one digit per clock, MSD first, computing acc = acc*10 + digit.
- Returns an N-bit binary result with overflow and invalid-digit flags; used in front of arithmetic datapaths fed by decimal keypad or display logic.

Parameters:
- N, 8, binary output width in bits.
- DIGITS, 3, number of BCD digits on the input; input width is 4*DIGITS.
- ACC_W, derived (not overridable), clog2(10**DIGITS); internal accumulator width, 10 for the defaults.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  BCD word on bcd_in is valid.
- in_ready  output  1  block can accept a word.
- bcd_in  input  4*DIGITS  packed BCD; digit DIGITS-1 (MSD) in the top nibble.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- data_out  output  N  binary result.
- ovf  output  1  decimal value exceeds 2**N-1.
- err  output  1  at least one input nibble is greater than 9.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst_n) is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - out_valid = 0, data_out = 0, ovf = 0, err = 0.
  - Accumulator, shift register and digit counter all 0.
  - in_ready = 1 (in_ready = state==IDLE, so it also reads 1 while rst_n is low).
- States:
  - IDLE, CONV, DONE. Encoding comes from the package enum.
- IDLE:
  - Handshake fires when in_valid && in_ready at a rising edge.
  - On that edge: latch bcd_in into the shift register, acc <= 0, cnt <= 0.
  - Also on that edge: err_r <= OR over nibbles of (nibble > 9). Go to CONV.
- CONV:
  - Each edge: acc <= (acc<<3) + (acc<<1) + top nibble; shift register <<= 4; cnt++.
  - On the edge where cnt == DIGITS-1, go to DONE and register the outputs.
  - in_ready = 0 throughout CONV. in_valid is ignored.
- Output registration (on the CONV-to-DONE edge):
  - ovf <= (final acc > 2**N-1).
  - data_out <= 0 if err. Otherwise the low N bits of acc, or the saturated value (see Optional Feature).
  - out_valid <= 1.
- Latency: out_valid rises DIGITS edges after the accepting edge (3 for defaults). No throughput overlap; one conversion in flight at a time.
- DONE:
  - data_out, ovf and err stay stable while out_valid && !out_ready.
  - On an edge with out_ready = 1: out_valid <= 0, go to IDLE.
  - in_ready returns to 1 the cycle after the result handshake.
- Width rules: the accumulator is ACC_W bits and cannot overflow internally. The digit adder zero-extends the nibble. Invalid nibbles (>9) are still accumulated, but the result is masked by err.
- Boundary cases:
  - 0x000 gives 0.
  - Maximum all-nines input gives 999, with ovf set for N=8.
  - If ACC_W <= N, ovf is constant 0.
  - DIGITS=1 gives a one-cycle CONV.
  - out_ready held high in IDLE or CONV has no effect.
  - rst_n asserted during CONV or DONE aborts immediately; the pending result is discarded and the next conversion behaves as from power-on.

Optional Feature:
- Macro: BCD2BIN_SAT_EN.
- Defined: on ovf, data_out = 2**N-1 (saturate).
- Undefined: on ovf, data_out = acc[N-1:0] (wrap).
- ovf and err behave identically in both builds. With err set, data_out = 0 regardless of the macro.

Decomposition:
- Package bcd_pkg:
  - state_t enum {IDLE, CONV, DONE}.
  - Function bcd_acc_w(digits) returning clog2(10**digits).
  - Constant BCD_DIGIT_MAX = 4'd9.
- Sub-module bcd_digit_mac:
  - Combinational acc*10 + digit using shift-adds, parameterised by ACC_W.
  - Instantiated once inside bcd2bin_seq.
  - The FSM, counter and handshake logic stay in the top module.

Test Plan:
- bcd_in=12'h255, out_ready=1: out_valid 3 edges after accept, data_out=8'hFF, ovf=0, err=0. Then bcd_in=12'h000 gives 8'h00.
- bcd_in=12'h256: ovf=1. data_out=8'h00 (wrap) without the macro, 8'hFF with BCD2BIN_SAT_EN. bcd_in=12'h999 gives ovf=1 and wrap value 8'hE7.
- bcd_in=12'h1A3: err=1, data_out=8'h00. The next input 12'h042 gives 8'h2A, err=0.
- Backpressure: convert 12'h128 with out_ready held 0 for 5 cycles. out_valid stays high, data_out=8'h80 stays stable, in_ready=0. Release out_ready: returns to IDLE the next cycle.
- rst_n pulsed low mid-CONV of 12'h200: all outputs 0 immediately. A following 12'h017 gives 8'h11 with normal latency.
- Exhaustive sweep 0..255 as BCD: each data_out matches its decimal value, ovf=0.
